// File: rtl/serial_mag_comparator_if.sv
// serial_mag_comparator_if
//   Bundle of the bit-serial compare link and its result flags.
//   master : drives start / bit_valid / a_bit / b_bit, observes status and flags
//   slave  : the comparator, consumes bit pairs and drives status and flags
//   start      begin a new compare
//   bit_valid  a_bit/b_bit carry a valid bit pair this cycle
//   a_bit      current bit of A, MSB first
//   b_bit      current bit of B, MSB first
//   busy       compare in progress
//   decided    a differing bit pair has been seen in this compare
//   done       one-cycle pulse: result flags just became valid
//   a_eq_b     A == B
//   a_gt_b     A >  B
//   a_lt_b     A <  B
interface serial_mag_comparator_if;
   logic start;
   logic bit_valid;
   logic a_bit;
   logic b_bit;
   logic busy;
   logic decided;
   logic done;
   logic a_eq_b;
   logic a_gt_b;
   logic a_lt_b;

   modport master (
      output start, bit_valid, a_bit, b_bit,
      input  busy, decided, done, a_eq_b, a_gt_b, a_lt_b
   );

   modport slave (
      input  start, bit_valid, a_bit, b_bit,
      output busy, decided, done, a_eq_b, a_gt_b, a_lt_b
   );
endinterface

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//   Bit-serial magnitude comparator for two unsigned WIDTH-bit operands that
//   arrive MSB first, one bit pair per valid beat. Reports equal / greater /
//   less once all WIDTH beats have been consumed.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_mag_comparator_if.slave (start, bit pairs, status, flags)
module serial_mag_comparator #(
   parameter int WIDTH = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   serial_mag_comparator_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] REL_EQ = 2'd0;
   localparam logic [1:0] REL_GT = 2'd1;
   localparam logic [1:0] REL_LT = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] count;
   logic [1:0]    rel;
   logic [1:0]    relNext;
   logic          eqQ;
   logic          gtQ;
   logic          ltQ;
   logic          startAccept;
   logic          beat;

   assign startAccept = bus.start && ((state == IDLE) || (state == DONE));
   assign beat        = (state == SHIFT) && bus.bit_valid;

   // The first differing bit pair (MSB first) decides; after that rel is sticky.
   always_comb begin
      relNext = rel;
      if (beat && (rel == REL_EQ) && (bus.a_bit != bus.b_bit)) begin
         relNext = bus.a_bit ? REL_GT : REL_LT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         rel   <= REL_EQ;
         eqQ   <= 1'b0;
         gtQ   <= 1'b0;
         ltQ   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (startAccept) begin
                  state <= SHIFT;
                  count <= CW'(WIDTH);
                  rel   <= REL_EQ;
                  eqQ   <= 1'b0;
                  gtQ   <= 1'b0;
                  ltQ   <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               if (bus.bit_valid) begin
                  rel   <= relNext;
                  count <= count - CW'(1);
                  if (count == CW'(1)) begin
                     state <= DONE;
                     eqQ   <= (relNext == REL_EQ);
                     gtQ   <= (relNext == REL_GT);
                     ltQ   <= (relNext == REL_LT);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy    = (state == SHIFT);
   assign bus.done    = (state == DONE);
   // rel is cleared on every accepted start, so a non-EQ value means this
   // compare has already been decided.
   assign bus.decided = (rel != REL_EQ);
   assign bus.a_eq_b  = eqQ;
   assign bus.a_gt_b  = gtQ;
   assign bus.a_lt_b  = ltQ;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator
//   Directed bench for serial_mag_comparator (WIDTH=4). Observed status is the
//   vector {busy, decided, done, a_eq_b, a_gt_b, a_lt_b}.
module tb_serial_mag_comparator;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [5:0] obs;
   logic [5:0] exp;

   serial_mag_comparator_if bus();

   serial_mag_comparator #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign obs = {bus.busy, bus.decided, bus.done, bus.a_eq_b, bus.a_gt_b, bus.a_lt_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic v, input logic a, input logic b);
      bus.start     = s;
      bus.bit_valid = v;
      bus.a_bit     = a;
      bus.b_bit     = b;
   endtask

   // A=1010 B=1001 on consecutive beats, preceded by reset checks.
   task automatic test_reset_and_gt();
      logic [3:0] av;
      logic [3:0] bv;
      logic [5:0] e [4];
      av = 4'b1010; bv = 4'b1001;
      e[0] = 6'b100000; e[1] = 6'b100000; e[2] = 6'b110000; e[3] = 6'b011010;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      exp = 6'b000000; checks++; if (obs !== exp) begin failures++; $display("FAIL reset obs=%b exp=%b", obs, exp); end
      tick();
      rst_n = 1'b1;
      tick();
      exp = 6'b000000; checks++; if (obs !== exp) begin failures++; $display("FAIL reset_idle obs=%b exp=%b", obs, exp); end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b100000; checks++; if (obs !== exp) begin failures++; $display("FAIL t1_start obs=%b exp=%b", obs, exp); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, av[3-i], bv[3-i]);
         tick();
         checks++; if (obs !== e[i]) begin failures++; $display("FAIL t1_beat%0d obs=%b exp=%b", i + 1, obs, e[i]); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b010010; checks++; if (obs !== exp) begin failures++; $display("FAIL t1_hold obs=%b exp=%b", obs, exp); end
   endtask

   // A=0110 B=0110: equal, decided never rises.
   task automatic test_equal();
      logic [3:0] v;
      v = 4'b0110;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b100000; checks++; if (obs !== exp) begin failures++; $display("FAIL t2_start obs=%b exp=%b", obs, exp); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, v[3-i], v[3-i]);
         tick();
         exp = (i == 3) ? 6'b001100 : 6'b100000;
         checks++; if (obs !== exp) begin failures++; $display("FAIL t2_beat%0d obs=%b exp=%b", i + 1, obs, exp); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b000100; checks++; if (obs !== exp) begin failures++; $display("FAIL t2_hold obs=%b exp=%b", obs, exp); end
   endtask

   // A=0011 B=1000: decided after beat 1; bit_valid with start is not consumed.
   task automatic test_early_decide();
      logic [3:0] av;
      logic [3:0] bv;
      av = 4'b0011; bv = 4'b1000;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      exp = 6'b100000; checks++; if (obs !== exp) begin failures++; $display("FAIL t3_start_ignores_bit obs=%b exp=%b", obs, exp); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, av[3-i], bv[3-i]);
         tick();
         exp = (i == 3) ? 6'b011001 : 6'b110000;
         checks++; if (obs !== exp) begin failures++; $display("FAIL t3_beat%0d obs=%b exp=%b", i + 1, obs, exp); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b010001; checks++; if (obs !== exp) begin failures++; $display("FAIL t3_hold obs=%b exp=%b", obs, exp); end
   endtask

   // A=1100 B=1101 with valid pattern 1,0,0,1,1,0,1; gap cycles carry decoy bits.
   task automatic test_gaps();
      logic [6:0] vp;
      logic [3:0] av;
      logic [3:0] bv;
      int         k;
      vp = 7'b1001101; av = 4'b1100; bv = 4'b1101; k = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b100000; checks++; if (obs !== exp) begin failures++; $display("FAIL t4_start obs=%b exp=%b", obs, exp); end
      for (int i = 0; i < 7; i++) begin
         if (vp[6-i]) begin
            drive(1'b0, 1'b1, av[3-k], bv[3-k]);
            k++;
         end else begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
         end
         tick();
         exp = (i == 6) ? 6'b011001 : 6'b100000;
         checks++; if (obs !== exp) begin failures++; $display("FAIL t4_cycle%0d obs=%b exp=%b", i + 1, obs, exp); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b010001; checks++; if (obs !== exp) begin failures++; $display("FAIL t4_hold obs=%b exp=%b", obs, exp); end
   endtask

   // start mid-SHIFT ignored, async reset after beat 2, then A=1111 B=0000.
   task automatic test_restart_and_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b100000; checks++; if (obs !== exp) begin failures++; $display("FAIL t5_start obs=%b exp=%b", obs, exp); end
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      exp = 6'b110000; checks++; if (obs !== exp) begin failures++; $display("FAIL t5_beat1 obs=%b exp=%b", obs, exp); end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b110000; checks++; if (obs !== exp) begin failures++; $display("FAIL t5_start_in_shift obs=%b exp=%b", obs, exp); end
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      exp = 6'b110000; checks++; if (obs !== exp) begin failures++; $display("FAIL t5_beat2 obs=%b exp=%b", obs, exp); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      exp = 6'b000000; checks++; if (obs !== exp) begin failures++; $display("FAIL t5_async_reset obs=%b exp=%b", obs, exp); end
      tick();
      rst_n = 1'b1;
      tick();
      exp = 6'b000000; checks++; if (obs !== exp) begin failures++; $display("FAIL t5_after_reset obs=%b exp=%b", obs, exp); end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b100000; checks++; if (obs !== exp) begin failures++; $display("FAIL t5_restart obs=%b exp=%b", obs, exp); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0);
         tick();
         exp = (i == 3) ? 6'b011010 : 6'b110000;
         checks++; if (obs !== exp) begin failures++; $display("FAIL t5_beat%0d obs=%b exp=%b", i + 1, obs, exp); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b010010; checks++; if (obs !== exp) begin failures++; $display("FAIL t5_hold obs=%b exp=%b", obs, exp); end
   endtask

   // A=0000 B=0001, then start in the DONE cycle for A=1000 B=0111.
   task automatic test_back_to_back();
      logic [3:0] av;
      logic [3:0] bv;
      av = 4'b0000; bv = 4'b0001;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b100000; checks++; if (obs !== exp) begin failures++; $display("FAIL t6_start obs=%b exp=%b", obs, exp); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, av[3-i], bv[3-i]);
         tick();
         exp = (i == 3) ? 6'b011001 : 6'b100000;
         checks++; if (obs !== exp) begin failures++; $display("FAIL t6a_beat%0d obs=%b exp=%b", i + 1, obs, exp); end
      end
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      exp = 6'b100000; checks++; if (obs !== exp) begin failures++; $display("FAIL t6_start_in_done obs=%b exp=%b", obs, exp); end
      av = 4'b1000; bv = 4'b0111;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, av[3-i], bv[3-i]);
         tick();
         exp = (i == 3) ? 6'b011010 : 6'b110000;
         checks++; if (obs !== exp) begin failures++; $display("FAIL t6b_beat%0d obs=%b exp=%b", i + 1, obs, exp); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      exp = 6'b010010; checks++; if (obs !== exp) begin failures++; $display("FAIL t6_hold obs=%b exp=%b", obs, exp); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset_and_gt();
      test_equal();
      test_early_decide();
      test_gaps();
      test_restart_and_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
